// File: rtl/fpga_ccff_loader.sv
// fpga_ccff_loader
// Streams a bitstream into NUM_CHAINS parallel configuration flip-flop
// chains of CHAIN_LEN flops each. It accepts one bit per chain per beat
// over a valid/ready stream and checks the bitstream length against
// CHAIN_LEN.
// Optional feature macro: FPGA_CCFF_LOADER_TAIL_PARITY_EN.
// When this macro is defined, the block accumulates a per-chain parity of
// the bits shifted out of ccff_tail.
`timescale 1ns/1ps

module fpga_ccff_loader #(
  parameter int NUM_CHAINS = 8,
  parameter int CHAIN_LEN  = 1024,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  bs_valid,
  input  logic [NUM_CHAINS-1:0] bs_data,
  input  logic                  bs_last,
  output logic                  bs_ready,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [NUM_CHAINS-1:0] tail_parity
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] beat_cnt;
  logic             accept;
  logic             last_slot;

  // Beats are accepted only while loading, and an abort blocks acceptance
  // in the same cycle.
  assign bs_ready  = (state == LOAD) & ~abort;
  assign accept    = bs_valid & bs_ready;
  assign last_slot = (beat_cnt == LAST_IDX);
  assign busy      = (state == LOAD);

  // Sequencing: start, count beats, and judge length, abort and completion.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            beat_cnt <= '0;
            err      <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (bs_last && last_slot) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (bs_last || last_slot) begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Register each accepted beat onto the chain heads along with its shift strobe.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      ccff_head     <= '0;
      config_enable <= 1'b0;
    end else begin
      config_enable <= accept;
      if (accept) begin
        ccff_head <= bs_data;
      end
    end
  end

`ifdef FPGA_CCFF_LOADER_TAIL_PARITY_EN
  // Fold each shifted-out tail bit into the per-chain parity. The parity is
  // cleared when a new load starts.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      tail_parity <= '0;
    end else if ((state == IDLE) && start) begin
      tail_parity <= '0;
    end else if (config_enable) begin
      tail_parity <= tail_parity ^ ccff_tail;
    end
  end
`else
  logic unused_tail;

  assign tail_parity = '0;
  assign unused_tail = ^ccff_tail;
`endif

endmodule
